// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Contents:
//   DEF_DW, DEF_AW, DEF_ENTRY - default data width, address width and entry count
//   slice_lo()                - low bit index of port `port` in a packed multi-port bus
package regfile_pkg;

  localparam int unsigned DEF_DW    = 32;
  localparam int unsigned DEF_AW    = 5;
  localparam int unsigned DEF_ENTRY = 32;

  // Ports are packed side by side; port k occupies [k*width +: width].
  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_sb.sv
// Busy-bit scoreboard, one bit per register file entry.
// Ports:
//   CLK, RSTN  - clock (rising edge), asynchronous active-low reset
//   set        - mark entry set_addr busy on the next edge
//   set_addr   - entry to mark busy
//   clr_en     - per write port: clear busy[clr_addr[k]] on the next edge
//   clr_addr   - per write port clear address, packed
//   busy       - current busy bits, entry e at bit e
// A set and a clear to the same entry in one cycle leave the bit set.
// Addresses >= ENTRY never match any entry and are ignored.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned ENTRY   = DEF_ENTRY,
  parameter int unsigned NW      = 2,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               set,
  input  logic [AW-1:0]      set_addr,
  input  logic [NW-1:0]      clr_en,
  input  logic [NW*AW-1:0]   clr_addr,
  output logic [ENTRY-1:0]   busy
);

  logic [AW-1:0]    ca [NW];
  logic [ENTRY-1:0] busy_d, busy_q;

  for (genvar k = 0; k < NW; k++) begin : g_ca
    assign ca[k] = clr_addr[slice_lo(k, AW) +: AW];
  end

  always_comb begin
    busy_d = busy_q;
    for (int unsigned e = 0; e < ENTRY; e++) begin
      for (int unsigned k = 0; k < NW; k++) begin
        if (clr_en[k] && (ca[k] == AW'(e))) busy_d[e] = 1'b0;
      end
      // Set is applied after the clears so it wins a same-cycle collision.
      if (set && (set_addr == AW'(e))) busy_d[e] = 1'b1;
    end
    if (ZERO_R0 != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with asynchronous reads and a busy scoreboard.
// Optional feature macro: REGFILE_MP_BYPASS_EN
//   defined   - a write in flight is forwarded to any read port addressing the same entry
//               in the same cycle, and that port's BUSY reads 0 (1 if SBSET also hits it)
//   undefined - reads show the contents and scoreboard as they stand before the edge
// Ports:
//   CLK, RSTN  - clock (rising edge), asynchronous active-low reset (clears data and busy)
//   WEN        - per write port enable, active low
//   WA, DI     - write address / data, port k at [k*AW +: AW] / [k*DW +: DW]
//   RA, DOUT   - read address / data, packed the same way
//   SBSET, SBA - mark entry SBA busy on the next edge
//   BUSY       - busy flag of the entry addressed by each read port
// Higher-index write ports win address collisions. Addresses >= ENTRY are ignored and read 0.
// With ZERO_R0 != 0 entry 0 reads 0, ignores writes and is never busy.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned ENTRY   = DEF_ENTRY,
  parameter int unsigned NR      = 2,
  parameter int unsigned NW      = 2,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic [NW-1:0]      WEN,
  input  logic [NW*AW-1:0]   WA,
  input  logic [NW*DW-1:0]   DI,
  input  logic [NR*AW-1:0]   RA,
  output logic [NR*DW-1:0]   DOUT,
  input  logic               SBSET,
  input  logic [AW-1:0]      SBA,
  output logic [NR-1:0]      BUSY
);

  logic [AW-1:0]    wa [NW];
  logic [DW-1:0]    di [NW];
  logic [AW-1:0]    ra [NR];
  logic [NW-1:0]    wr_ok;
  logic [DW-1:0]    mem_d [ENTRY];
  logic [DW-1:0]    mem_q [ENTRY];
  logic [ENTRY-1:0] busy;
  logic [DW-1:0]    rd_data [NR];
  logic [NR-1:0]    rd_busy;

  for (genvar k = 0; k < NW; k++) begin : g_wr
    assign wa[k] = WA[slice_lo(k, AW) +: AW];
    assign di[k] = DI[slice_lo(k, DW) +: DW];
    // A write counts only if it lands on a real, writable entry.
    assign wr_ok[k] = ~WEN[k] & (32'(wa[k]) < ENTRY) & ~((ZERO_R0 != 0) && (wa[k] == '0));
  end

  for (genvar j = 0; j < NR; j++) begin : g_rd
    assign ra[j]                       = RA[slice_lo(j, AW) +: AW];
    assign DOUT[slice_lo(j, DW) +: DW] = rd_data[j];
  end
  assign BUSY = rd_busy;

  always_comb begin
    for (int unsigned e = 0; e < ENTRY; e++) begin
      mem_d[e] = mem_q[e];
      // Ascending port order makes the highest-index port win.
      for (int unsigned k = 0; k < NW; k++) begin
        if (wr_ok[k] && (wa[k] == AW'(e))) mem_d[e] = di[k];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int unsigned e = 0; e < ENTRY; e++) mem_q[e] <= '0;
    end else begin
      for (int unsigned e = 0; e < ENTRY; e++) mem_q[e] <= mem_d[e];
    end
  end

  regfile_sb #(
    .AW      (AW),
    .ENTRY   (ENTRY),
    .NW      (NW),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .set      (SBSET),
    .set_addr (SBA),
    .clr_en   (wr_ok),
    .clr_addr (WA),
    .busy     (busy)
  );

  always_comb begin
    for (int unsigned j = 0; j < NR; j++) begin
      rd_data[j] = '0;
      rd_busy[j] = 1'b0;
      for (int unsigned e = 0; e < ENTRY; e++) begin
        if (ra[j] == AW'(e)) begin
          rd_data[j] = mem_q[e];
          rd_busy[j] = busy[e];
        end
      end
`ifdef REGFILE_MP_BYPASS_EN
      // Gated by RSTN so outputs stay 0 throughout reset.
      for (int unsigned k = 0; k < NW; k++) begin
        if (RSTN && wr_ok[k] && (wa[k] == ra[j])) begin
          rd_data[j] = di[k];
          rd_busy[j] = SBSET && (SBA == ra[j]);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 5;
  localparam int unsigned ENTRY   = 24;
  localparam int unsigned NR      = 2;
  localparam int unsigned NW      = 2;
  localparam int unsigned ZERO_R0 = 1;

  logic             CLK = 1'b0;
  logic             RSTN;
  logic [NW-1:0]    WEN;
  logic [NW*AW-1:0] WA;
  logic [NW*DW-1:0] DI;
  logic [NR*AW-1:0] RA;
  logic [NR*DW-1:0] DOUT;
  logic             SBSET;
  logic [AW-1:0]    SBA;
  logic [NR-1:0]    BUSY;

  always #5 CLK = ~CLK;

  regfile_mp #(
    .DW      (DW),
    .AW      (AW),
    .ENTRY   (ENTRY),
    .NR      (NR),
    .NW      (NW),
    .ZERO_R0 (ZERO_R0)
  ) dut (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .WEN   (WEN),
    .WA    (WA),
    .DI    (DI),
    .RA    (RA),
    .DOUT  (DOUT),
    .SBSET (SBSET),
    .SBA   (SBA),
    .BUSY  (BUSY)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference state: plain arrays of entry contents and busy flags.
  logic [DW-1:0] ref_mem  [ENTRY];
  bit            ref_busy [ENTRY];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned waddr(input int unsigned k);
    return int'(WA[k*AW +: AW]);
  endfunction

  function automatic int unsigned raddr(input int unsigned j);
    return int'(RA[j*AW +: AW]);
  endfunction

  function automatic bit wr_valid(input int unsigned k);
    return !WEN[k] && (waddr(k) < ENTRY) && !(ZERO_R0 != 0 && waddr(k) == 0);
  endfunction

  function automatic logic [DW-1:0] exp_dout(input int unsigned j);
    logic [DW-1:0] v;
    if (!RSTN || raddr(j) >= ENTRY) return '0;
    v = ref_mem[raddr(j)];
`ifdef REGFILE_MP_BYPASS_EN
    for (int unsigned k = 0; k < NW; k++)
      if (wr_valid(k) && waddr(k) == raddr(j)) v = DI[k*DW +: DW];
`endif
    return v;
  endfunction

  function automatic bit exp_busy(input int unsigned j);
    bit b;
    if (!RSTN || raddr(j) >= ENTRY) return 1'b0;
    b = ref_busy[raddr(j)];
`ifdef REGFILE_MP_BYPASS_EN
    for (int unsigned k = 0; k < NW; k++)
      if (wr_valid(k) && waddr(k) == raddr(j)) b = SBSET && (int'(SBA) == raddr(j));
`endif
    return b;
  endfunction

  task automatic ref_reset();
    for (int unsigned e = 0; e < ENTRY; e++) begin
      ref_mem[e]  = '0;
      ref_busy[e] = 1'b0;
    end
  endtask

  task automatic ref_clock();
    if (!RSTN) return;
    for (int unsigned k = 0; k < NW; k++) begin
      if (wr_valid(k)) begin
        ref_mem[waddr(k)]  = DI[k*DW +: DW];
        ref_busy[waddr(k)] = 1'b0;
      end
    end
    if (SBSET && int'(SBA) < ENTRY && !(ZERO_R0 != 0 && SBA == '0)) ref_busy[SBA] = 1'b1;
  endtask

  task automatic drive(input logic [1:0] wen, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                       input logic [DW-1:0] di0, input logic [DW-1:0] di1,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                       input logic sbset, input logic [AW-1:0] sba);
    WEN   = wen;
    WA    = {wa1, wa0};
    DI    = {di1, di0};
    RA    = {ra1, ra0};
    SBSET = sbset;
    SBA   = sba;
  endtask

  task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    drive(2'b11, '0, '0, '0, '0, ra0, ra1, 1'b0, '0);
  endtask

  // Called just after a falling edge with inputs applied: checks outputs against the
  // reference, advances one rising edge, and returns on the next falling edge.
  task automatic step(input string tag);
    #1;
    for (int unsigned j = 0; j < NR; j++) begin
      check_eq($sformatf("%s_dout%0d", tag, j), DOUT[j*DW +: DW], exp_dout(j));
      check_eq($sformatf("%s_busy%0d", tag, j), 32'(BUSY[j]), 32'(exp_busy(j)));
    end
    @(posedge CLK);
    ref_clock();
    @(negedge CLK);
  endtask

  initial begin
    RSTN = 1'b0;
    ref_reset();
    idle(5'd3, 5'd0);
    @(negedge CLK);

    // Reset state, and a write attempted while in reset must not land.
    drive(2'b10, 5'd3, 5'd0, 32'h1234_5678, '0, 5'd3, 5'd0, 1'b1, 5'd3);
    #1;
    check_eq("rst_dout0", DOUT[31:0], 32'h0);
    check_eq("rst_busy0", 32'(BUSY[0]), 32'h0);
    step("rst");
    RSTN = 1'b1;
    idle(5'd3, 5'd3);
    #1;
    check_eq("rst_nowr", DOUT[31:0], 32'h0);
    step("post_rst");

    // Write then read.
    drive(2'b10, 5'd3, 5'd0, 32'hDEAD_BEEF, '0, 5'd0, 5'd0, 1'b0, '0);
    step("w3");
    idle(5'd3, 5'd0);
    #1;
    check_eq("w3_read", DOUT[31:0], 32'hDEAD_BEEF);
    step("r3");

    // Write collision: port 1 wins.
    drive(2'b00, 5'd5, 5'd5, 32'h11, 32'h22, 5'd0, 5'd0, 1'b0, '0);
    step("coll");
    idle(5'd5, 5'd5);
    #1;
    check_eq("coll_read", DOUT[63:32], 32'h22);
    step("coll_r");

    // Entry 0 is hardwired.
    drive(2'b10, 5'd0, 5'd0, 32'hFFFF_FFFF, '0, 5'd0, 5'd0, 1'b1, 5'd0);
    step("z0");
    idle(5'd0, 5'd0);
    #1;
    check_eq("z0_dout", DOUT[31:0], 32'h0);
    check_eq("z0_busy", 32'(BUSY[0]), 32'h0);
    step("z0_r");

    // Scoreboard: set, hold two cycles, clear by a write.
    drive(2'b11, '0, '0, '0, '0, 5'd7, 5'd0, 1'b1, 5'd7);
    step("sb_set");
    idle(5'd7, 5'd0);
    #1;
    check_eq("sb_hold1", 32'(BUSY[0]), 32'h1);
    step("sb_h1");
    drive(2'b01, 5'd0, 5'd7, '0, 32'h77, 5'd7, 5'd0, 1'b0, '0);
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    check_eq("sb_hold2", 32'(BUSY[0]), 32'h0);
`else
    check_eq("sb_hold2", 32'(BUSY[0]), 32'h1);
`endif
    step("sb_clr");
    idle(5'd7, 5'd0);
    #1;
    check_eq("sb_cleared", 32'(BUSY[0]), 32'h0);
    step("sb_c");
    drive(2'b10, 5'd7, 5'd0, 32'h78, '0, 5'd7, 5'd0, 1'b1, 5'd7);
    step("sb_both");
    idle(5'd7, 5'd0);
    #1;
    check_eq("sb_set_wins", 32'(BUSY[0]), 32'h1);
    step("sb_w");

    // Bypass versus pre-edge read.
    drive(2'b10, 5'd9, 5'd0, 32'h33, '0, 5'd0, 5'd0, 1'b0, '0);
    step("bp_old");
    drive(2'b10, 5'd9, 5'd0, 32'hA5, '0, 5'd0, 5'd9, 1'b0, '0);
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    check_eq("bp_same", DOUT[63:32], 32'hA5);
`else
    check_eq("bp_same", DOUT[63:32], 32'h33);
`endif
    step("bp");
    idle(5'd0, 5'd9);
    #1;
    check_eq("bp_after", DOUT[63:32], 32'hA5);
    step("bp_r");

    // Out-of-range addresses alongside a write to the last valid entry.
    drive(2'b00, 5'd30, 5'd23, 32'h77, 32'h44, 5'd30, 5'd23, 1'b1, 5'd30);
    step("oor");
    idle(5'd30, 5'd23);
    #1;
    check_eq("oor_dout", DOUT[31:0], 32'h0);
    check_eq("oor_busy", 32'(BUSY[0]), 32'h0);
    check_eq("last_entry", DOUT[63:32], 32'h44);
    step("oor_r");

    // Reset mid-operation.
    for (int unsigned i = 1; i <= 4; i++) begin
      drive(2'b10, AW'(i), '0, 32'h100 + i, '0, '0, '0, 1'b0, '0);
      step("pop");
    end
    drive(2'b11, '0, '0, '0, '0, 5'd2, 5'd1, 1'b1, 5'd2);
    step("pop_sb");
    idle(5'd2, 5'd1);
    #1;
    check_eq("pre_rst_dout", DOUT[31:0], 32'h102);
    check_eq("pre_rst_busy", 32'(BUSY[0]), 32'h1);
    #1;
    RSTN = 1'b0;
    ref_reset();
    drive(2'b01, '0, 5'd4, '0, 32'hBAD, 5'd2, 5'd4, 1'b1, 5'd4);
    #1;
    check_eq("mid_rst_dout0", DOUT[31:0], 32'h0);
    check_eq("mid_rst_dout1", DOUT[63:32], 32'h0);
    check_eq("mid_rst_busy0", 32'(BUSY[0]), 32'h0);
    step("mid_rst");
    RSTN = 1'b1;
    idle(5'd4, 5'd1);
    #1;
    check_eq("mid_rst_nowr", DOUT[31:0], 32'h0);
    check_eq("mid_rst_nobusy", 32'(BUSY[0]), 32'h0);
    step("post_mid");

    // Randomized traffic.
    for (int unsigned n = 0; n < 400; n++) begin
      drive(2'($urandom), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            $urandom, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'($urandom), 5'($urandom_range(0, 31)));
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
